// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: fetches one word over a req/ack port, then decodes RV32I
// into the 7-bit ALUSEL control word plus register and immediate fields.
module instr_fetch_decode #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_en,
  input  logic             ID_en,
  input  logic [31:0]      pc_in,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [6:0]       ALUSEL,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic             funct7_5,
  output logic [31:0]      imm,
  output logic             auipc,
  output logic             illegal,
  output logic             fetch_err,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [31:0] ir, ir_nxt;
  logic        ir_valid, ir_valid_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic        timeout_hit;
  logic        ack_take;

  // imem handshake: imem_req stays high from the cycle after PC_en until imem_ack
  // is sampled in FETCH (or the timer expires); imem_ack is a one-cycle strobe
  // qualifying imem_rdata and is only honoured while in FETCH.
  assign ack_take  = (state == FETCH) && imem_ack && !PC_en;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      ir        <= ir_nxt;
      ir_valid  <= ir_valid_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    ir_nxt       = ir;
    ir_valid_nxt = ir_valid;
    req_nxt      = imem_req;
    addr_nxt     = imem_addr;
    timeout_hit  = 1'b0;
    if (PC_en) begin
      addr_nxt     = pc_in;
      req_nxt      = 1'b1;
      ir_valid_nxt = 1'b0;
      timer_nxt    = '0;
      state_nxt    = FETCH;
    end else if (state == FETCH) begin
      if (imem_ack) begin
        ir_nxt       = imem_rdata;
        ir_valid_nxt = 1'b1;
        req_nxt      = 1'b0;
        state_nxt    = HOLD;
      end else if (timer == 8'(TIMEOUT - 1)) begin
        req_nxt     = 1'b0;
        timeout_hit = 1'b1;
        state_nxt   = IDLE;
      end else begin
        timer_nxt = timer + 8'd1;
      end
    end
  end

  // Decode source: an ack arriving with ID_en is decoded directly.
  logic [31:0] src;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  dec_alusel;
  logic [31:0] dec_imm;
  logic        dec_auipc;
  logic        dec_illegal;

  assign src   = ack_take ? imem_rdata : ir;
  assign imm_i = {{20{src[31]}}, src[31:20]};
  assign imm_s = {{20{src[31]}}, src[31:25], src[11:7]};
  assign imm_b = {{19{src[31]}}, src[31], src[7], src[30:25], src[11:8], 1'b0};
  assign imm_u = {src[31:12], 12'd0};
  assign imm_j = {{11{src[31]}}, src[31], src[19:12], src[20], src[30:21], 1'b0};

  always_comb begin
    dec_alusel  = '0;
    dec_imm     = '0;
    dec_auipc   = 1'b0;
    dec_illegal = 1'b0;
    case (src[6:0])
      7'b0110011: dec_alusel = 7'b0000001;
      7'b0010011: begin dec_alusel = 7'b0100001; dec_imm = imm_i; end
      7'b0000011: begin dec_alusel = 7'b0101101; dec_imm = imm_i; end
      7'b0100011: begin dec_alusel = 7'b0111001; dec_imm = imm_s; end
      7'b1100011: begin dec_alusel = 7'b1000000; dec_imm = imm_b; end
      7'b1101111: begin dec_alusel = 7'b1100011; dec_imm = imm_j; end
      7'b1100111: begin dec_alusel = 7'b1100011; dec_imm = imm_i; end
      7'b0110111: begin dec_alusel = 7'b0100111; dec_imm = imm_u; end
      7'b0010111: begin dec_alusel = 7'b0100001; dec_imm = imm_u; dec_auipc = 1'b1; end
      default:    dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUSEL      <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      funct3      <= '0;
      funct7_5    <= 1'b0;
      imm         <= '0;
      auipc       <= 1'b0;
      illegal     <= 1'b0;
      fetch_err   <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      illegal   <= 1'b0;
      fetch_err <= timeout_hit;
      if (ID_en) begin
        if ((ack_take || ir_valid) && !dec_illegal) begin
          ALUSEL   <= dec_alusel;
          rs1      <= src[19:15];
          rs2      <= src[24:20];
          rd       <= src[11:7];
          funct3   <= src[14:12];
          funct7_5 <= src[30];
          imm      <= dec_imm;
          auipc    <= dec_auipc;
        end else begin
          // Unknown opcode or nothing fetched: NOP with cleared fields.
          ALUSEL   <= '0;
          rs1      <= '0;
          rs2      <= '0;
          rd       <= '0;
          funct3   <= '0;
          funct7_5 <= 1'b0;
          imm      <= '0;
          auipc    <= 1'b0;
          if (ack_take || ir_valid) begin
            illegal <= 1'b1;
            if (illegal_cnt != {CNT_W{1'b1}})
              illegal_cnt <= illegal_cnt + 1'b1;
          end else begin
            fetch_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: fetch/decode sequences checked against
// hand-derived decode results queued at ID_en and popped one cycle later.
module tb_instr_fetch_decode;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;
  localparam int W       = 59;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             PC_en = 1'b0;
  logic             ID_en = 1'b0;
  logic [31:0]      pc_in = '0;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack = 1'b0;
  logic [31:0]      imem_rdata = '0;
  logic [6:0]       ALUSEL;
  logic [4:0]       rs1, rs2, rd;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [31:0]      imm;
  logic             auipc;
  logic             illegal;
  logic             fetch_err;
  logic [CNT_W-1:0] illegal_cnt;
  logic [1:0]       state_dbg;

  int tests_run = 0;
  int failures  = 0;
  logic [W-1:0] exp_q[$];

  instr_fetch_decode #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .PC_en(PC_en), .ID_en(ID_en), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ALUSEL(ALUSEL), .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct3(funct3), .funct7_5(funct7_5), .imm(imm), .auipc(auipc),
    .illegal(illegal), .fetch_err(fetch_err), .illegal_cnt(illegal_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pk(input logic [6:0] a, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [2:0] f3, input logic f75,
                                      input logic [31:0] im, input logic au);
    return {a, d, s1, s2, f3, f75, im, au};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int lat);
    @(negedge clk);
    PC_en = 1'b1;
    pc_in = pc;
    @(negedge clk);
    PC_en = 1'b0;
    check("imem_addr", 64'(imem_addr), 64'(pc));
    for (int i = 1; i <= lat; i++) begin
      check("req_high", 64'(imem_req), 64'd1);
      if (i == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = data;
      end
      @(negedge clk);
      imem_ack = 1'b0;
    end
    check("req_drop", 64'(imem_req), 64'd0);
    check("state_hold", 64'(state_dbg), 64'd2);
  endtask

  task automatic do_decode(input logic [W-1:0] exp, input logic exp_err, input logic exp_ill);
    logic [W-1:0] e;
    ID_en = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    ID_en = 1'b0;
    e = exp_q.pop_front();
    check("decode", 64'({ALUSEL, rd, rs1, rs2, funct3, funct7_5, imm, auipc}), 64'(e));
    check("fetch_err", 64'(fetch_err), 64'(exp_err));
    check("illegal", 64'(illegal), 64'(exp_ill));
  endtask

  logic [W-1:0] addi_exp, lui_exp;

  initial begin
    addi_exp = pk(7'b0100001, 5'd6, 5'd6, 5'd10, 3'd0, 1'b0, 32'd10, 1'b0);
    lui_exp  = pk(7'b0100111, 5'd10, 5'd8, 5'd3, 3'd5, 1'b0, 32'h12345000, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_outs", 64'({ALUSEL, rd, rs1, rs2, funct3, funct7_5, imm, auipc}), 64'd0);
    check("rst_flags", 64'({illegal, fetch_err, illegal_cnt, state_dbg}), 64'd0);
    rst = 1'b0;

    // addi x6,x6,10 with a three-cycle ack latency
    do_fetch(32'h40, 32'h00A30313, 3);
    do_decode(addi_exp, 1'b0, 1'b0);
    // sw x1,-4(x2)
    do_fetch(32'h44, 32'hFE112E23, 1);
    do_decode(pk(7'b0111001, 5'd28, 5'd2, 5'd1, 3'd2, 1'b1, 32'hFFFFFFFC, 1'b0), 1'b0, 1'b0);
    // jal x1,8 then lui
    do_fetch(32'h48, 32'h008000EF, 2);
    do_decode(pk(7'b1100011, 5'd1, 5'd0, 5'd8, 3'd0, 1'b0, 32'd8, 1'b0), 1'b0, 1'b0);
    do_fetch(32'h4C, 32'h12345537, 1);
    do_decode(lui_exp, 1'b0, 1'b0);
    // stray ack in HOLD must not overwrite the held instruction
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    do_decode(lui_exp, 1'b0, 1'b0);
    // beq x1,x2,8 and auipc x5,1
    do_fetch(32'h50, 32'h00208463, 1);
    do_decode(pk(7'b1000000, 5'd8, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8, 1'b0), 1'b0, 1'b0);
    do_fetch(32'h54, 32'h00001297, 2);
    do_decode(pk(7'b0100001, 5'd5, 5'd0, 5'd0, 3'd1, 1'b0, 32'h1000, 1'b1), 1'b0, 1'b0);

    // random addi encodings
    for (int n = 0; n < 6; n++) begin
      logic [11:0] i12;
      logic [4:0]  r1, r0;
      i12 = 12'($urandom_range(0, 4095));
      r1  = 5'($urandom_range(0, 31));
      r0  = 5'($urandom_range(0, 31));
      do_fetch(32'h100 + 32'(n * 4), {i12, r1, 3'b000, r0, 7'b0010011}, $urandom_range(1, 5));
      do_decode(pk(7'b0100001, r0, r1, i12[4:0], 3'd0, i12[10], {{20{i12[11]}}, i12}, 1'b0),
                1'b0, 1'b0);
    end

    // timeout: req high for TIMEOUT cycles, then fetch_err pulse
    @(negedge clk);
    PC_en = 1'b1;
    pc_in = 32'h200;
    @(negedge clk);
    PC_en = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      check("to_req_high", 64'(imem_req), 64'd1);
      check("to_no_err", 64'(fetch_err), 64'd0);
      @(negedge clk);
    end
    check("to_req_drop", 64'(imem_req), 64'd0);
    check("to_err_pulse", 64'(fetch_err), 64'd1);
    check("to_state_idle", 64'(state_dbg), 64'd0);
    @(negedge clk);
    check("to_err_clear", 64'(fetch_err), 64'd0);
    do_decode('0, 1'b1, 1'b0);

    // illegal opcodes, counter saturates
    for (int k = 1; k <= 260; k++) begin
      do_fetch(32'h300, 32'hFFFFFFFF, 1);
      do_decode('0, 1'b0, 1'b1);
      check("illegal_cnt", 64'(illegal_cnt), 64'((k > 255) ? 255 : k));
    end

    // mid-FETCH asynchronous reset
    do_fetch(32'h400, 32'h00A30313, 1);
    do_decode(addi_exp, 1'b0, 1'b0);
    @(negedge clk);
    PC_en = 1'b1;
    pc_in = 32'h404;
    @(negedge clk);
    PC_en = 1'b0;
    check("pre_rst_req", 64'(imem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_req", 64'(imem_req), 64'd0);
    check("async_outs", 64'({ALUSEL, rd, rs1, rs2, funct3, funct7_5, imm, auipc}), 64'd0);
    check("async_cnt", 64'(illegal_cnt), 64'd0);
    check("async_addr", 64'(imem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ID_en coincident with ack decodes the ack data directly
    @(negedge clk);
    PC_en = 1'b1;
    pc_in = 32'h80;
    @(negedge clk);
    PC_en = 1'b0;
    @(negedge clk);
    check("byp_req", 64'(imem_req), 64'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h00A30313;
    do_decode(addi_exp, 1'b0, 1'b0);
    imem_ack = 1'b0;
    check("byp_req_drop", 64'(imem_req), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
